// File: rtl/mul_share_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mul_share_arbiter_pkg
// Shared definitions for the multiplier-sharing arbiter slice:
//   - OP_W    : operand width fed into the shared multiplier (4)
//   - PROD_W  : product width, wide enough for 15*15 without truncation (8)
//   - state_t : arbiter FSM encoding (IDLE=0, MUL=1, HOLD=2)
// Configuration macro used by this slice: MUL_ARB_RR_EN
// ----------------------------------------------------------------------------
package mul_share_arbiter_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/Multiplier.sv
// ----------------------------------------------------------------------------
// Multiplier
// The lab's existing combinational 4x4 unsigned multiplier datapath.
// Ports:
//   a, b : 4-bit unsigned operands
//   p    : 8-bit unsigned product a*b
// ----------------------------------------------------------------------------
module Multiplier (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    // Zero-extend both operands first so the product keeps all eight bits.
    assign p = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/mul_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mul_rr_arbiter
// Combinational grant select for the multiplier-sharing arbiter.
// Configuration macro: MUL_ARB_RR_EN
//   defined   : round-robin search starting one past the last grant; this
//               module then owns the pointer register (reset to N_REQ-1)
//   undefined : fixed priority, lowest valid index wins, no pointer built
// Ports:
//   clk, rst_n : clock / async active-low reset (round-robin build only)
//   advance    : a grant is being taken this cycle (round-robin build only)
//   req_valid  : per-requester valid
//   any_valid  : at least one requester is valid
//   grant      : one-hot grant (all zero when nothing is valid)
//   grant_idx  : index of the granted requester
// ----------------------------------------------------------------------------
module mul_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
`ifdef MUL_ARB_RR_EN
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
`endif
    input  logic [N_REQ-1:0] req_valid,
    output logic             any_valid,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

`ifdef MUL_ARB_RR_EN
    logic [ID_W-1:0] ptr;

    // The pointer remembers the last granted requester so the next search
    // begins just after it; resetting to N_REQ-1 makes requester 0 first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= ID_W'(N_REQ - 1);
        end else if (advance) begin
            ptr <= grant_idx;
        end
    end

    // Walk the requesters starting at ptr+1, wrapping modulo N_REQ, and take
    // the first valid one. Works for non-power-of-two N_REQ as well.
    always_comb begin
        int idx;
        idx       = 0;
        any_valid = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!any_valid && req_valid[idx]) begin
                any_valid = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
        grant = any_valid ? (N_REQ'(1) << grant_idx) : '0;
    end
`else
    // Scan from the top down so the lowest valid index is the last writer
    // and therefore wins.
    always_comb begin
        any_valid = 1'b0;
        grant_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_valid = 1'b1;
                grant_idx = ID_W'(i);
            end
        end
        grant = any_valid ? (N_REQ'(1) << grant_idx) : '0;
    end
`endif

endmodule

// File: rtl/mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// mul_share_arbiter
// Time-shares one 4x4 Multiplier among N_REQ requesters. A requester is
// granted in IDLE, its operands are registered, the product is captured in
// MUL, and the tagged result is held in HOLD until the consumer accepts it.
// Configuration macro: MUL_ARB_RR_EN (round-robin vs. fixed priority).
// Ports:
//   clk, rst_n : clock / async active-low reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept, at most one bit high, IDLE only
//   req_a/b    : packed 4-bit operands, requester i at [4i+3:4i]
//   res_valid  : result held and valid
//   res_ready  : consumer accepts the result
//   res_p      : 8-bit unsigned product
//   res_id     : index of the requester that produced res_p
// ----------------------------------------------------------------------------
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [4*N_REQ-1:0] req_a,
    input  logic [4*N_REQ-1:0] req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [PROD_W-1:0]  res_p,
    output logic [ID_W-1:0]    res_id
);

    state_t             state;
    logic [OP_W-1:0]    op_a;
    logic [OP_W-1:0]    op_b;
    logic [ID_W-1:0]    id_q;
    logic [PROD_W-1:0]  product;
    logic               any_valid;
    logic [N_REQ-1:0]   grant;
    logic [ID_W-1:0]    grant_idx;
    logic               advance;
    logic [OP_W-1:0]    sel_a;
    logic [OP_W-1:0]    sel_b;

    // A handshake only happens in IDLE; everywhere else all readies are low.
    assign advance   = (state == IDLE) && any_valid;
    assign req_ready = advance ? grant : '0;
    assign sel_a     = req_a[int'(grant_idx)*OP_W +: OP_W];
    assign sel_b     = req_b[int'(grant_idx)*OP_W +: OP_W];

    mul_rr_arbiter #(
        .N_REQ     (N_REQ),
        .ID_W      (ID_W)
    ) u_arb (
`ifdef MUL_ARB_RR_EN
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
`endif
        .req_valid (req_valid),
        .any_valid (any_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    Multiplier u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    // Main FSM: IDLE latches the granted operands and tag, MUL captures the
    // product into the output register, HOLD keeps the result steady until
    // the consumer takes it. Returning to IDLE costs one cycle, so a new
    // grant is never taken in the same cycle the result is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            id_q      <= '0;
            res_p     <= '0;
            res_id    <= '0;
            res_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        op_a  <= sel_a;
                        op_b  <= sel_b;
                        id_q  <= grant_idx;
                        state <= MUL;
                    end
                end
                MUL: begin
                    res_p     <= product;
                    res_id    <= id_q;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mul_share_arbiter
// Directed self-checking bench for mul_share_arbiter (N_REQ=4). Follows the
// MUL_ARB_RR_EN macro so contention expectations match the built arbiter.
// ----------------------------------------------------------------------------
module tb_mul_share_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_p;
    logic [1:0]  res_id;

    int compared   = 0;
    int mismatched = 0;

    mul_share_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_p     (res_p),
        .res_id    (res_id)
    );

    // Free-running 10-time-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the requester side of the bench.
    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] a_vec,
                                 input logic [15:0] b_vec);
        req_valid = valid;
        req_a     = a_vec;
        req_b     = b_vec;
    endtask

    // One comparison: count it, and on disagreement count and report it.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Step to just after the next rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction from IDLE: offer, check grant, check MUL,
    // check HOLD (optionally under back-pressure), accept, check return.
    task automatic doTxn(input string tag, input logic [3:0] valid,
                         input logic [15:0] a_vec, input logic [15:0] b_vec,
                         input int exp_g, input int hold_cycles, input bit keep_valid);
        logic [7:0] exp_p;
        logic [3:0] exp_ready;
        logic [3:0] oa;
        logic [3:0] ob;
        oa        = a_vec[4*exp_g +: 4];
        ob        = b_vec[4*exp_g +: 4];
        exp_p     = {4'd0, oa} * {4'd0, ob};
        exp_ready = 4'(1 << exp_g);
        applyStimulus(valid, a_vec, b_vec);
        #1;
        checkOutput({tag, " grant"}, 16'(req_ready), 16'(exp_ready));
        stepCycle();
        if (!keep_valid) applyStimulus(4'b0000, a_vec, b_vec);
        #1;
        checkOutput({tag, " mul ready"}, 16'(req_ready), 16'h0);
        checkOutput({tag, " mul valid"}, 16'(res_valid), 16'h0);
        stepCycle();
        checkOutput({tag, " valid"}, 16'(res_valid), 16'h1);
        checkOutput({tag, " prod"}, 16'(res_p), 16'(exp_p));
        checkOutput({tag, " id"}, 16'(res_id), 16'(exp_g));
        for (int h = 0; h < hold_cycles; h++) begin
            stepCycle();
            checkOutput({tag, " hold valid"}, 16'(res_valid), 16'h1);
            checkOutput({tag, " hold prod"}, 16'(res_p), 16'(exp_p));
            checkOutput({tag, " hold id"}, 16'(res_id), 16'(exp_g));
            checkOutput({tag, " hold ready"}, 16'(req_ready), 16'h0);
        end
        res_ready = 1'b1;
        #1;
        checkOutput({tag, " accept ready"}, 16'(req_ready), 16'h0);
        stepCycle();
        res_ready = 1'b0;
        if (!keep_valid) applyStimulus(4'b0000, a_vec, b_vec);
        checkOutput({tag, " idle valid"}, 16'(res_valid), 16'h0);
    endtask

    initial begin
        int exp_order [5];
        rst_n     = 1'b0;
        res_ready = 1'b0;
        applyStimulus(4'b0000, 16'h0, 16'h0);
        #12;
        checkOutput("reset ready", 16'(req_ready), 16'h0);
        checkOutput("reset valid", 16'(res_valid), 16'h0);
        checkOutput("reset prod", 16'(res_p), 16'h0);
        checkOutput("reset id", 16'(res_id), 16'h0);
        rst_n = 1'b1;

        // Idle for five cycles with nothing requested.
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput("idle ready", 16'(req_ready), 16'h0);
            checkOutput("idle valid", 16'(res_valid), 16'h0);
            checkOutput("idle prod", 16'(res_p), 16'h0);
        end

        // Requester 2 alone with the largest operands: 15*15 = 0xE1.
        doTxn("single", 4'b0100, 16'h0F00, 16'h0F00, 2, 0, 1'b0);

        // Requester 1, 3*5 = 15, held for six cycles of back-pressure while
        // still requesting; no new grant may appear during HOLD.
        doTxn("backpr", 4'b0010, 16'h0030, 16'h0050, 1, 6, 1'b1);
        applyStimulus(4'b0000, 16'h0, 16'h0);

        // Every operand pair on requester 0.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                doTxn("exh", 4'b0001, 16'(a), 16'(b), 0, 0, 1'b0);
            end
        end

        // Reset during MUL: the in-flight result must never appear.
        applyStimulus(4'b0010, 16'h0070, 16'h0090);
        #1;
        checkOutput("rst grant", 16'(req_ready), 16'h2);
        stepCycle();
        applyStimulus(4'b0000, 16'h0, 16'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("rst valid", 16'(res_valid), 16'h0);
        checkOutput("rst prod", 16'(res_p), 16'h0);
        checkOutput("rst id", 16'(res_id), 16'h0);
        stepCycle();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("rst no result", 16'(res_valid), 16'h0);
        end

        // All four requesters continuously valid straight after reset.
`ifdef MUL_ARB_RR_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            doTxn("contend", 4'b1111, 16'h4321, 16'h8765, exp_order[i], 0, 1'b1);
        end
        applyStimulus(4'b0000, 16'h0, 16'h0);
        stepCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
